piso_tx: RTL and testbench
==========================

// Module: piso_tx
// PURPOSE
//   Parallel-in serial-out transmitter. Accepts a WIDTH-bit word over a valid/ready
//   load handshake and shifts it out MSB-first, one bit per enabled cycle.
//   Counterpart of the sipo receiver: drive the receiver's serial_in from serial_out,
//   and its shift_en from (shift_en & serial_valid). After WIDTH shifts the receiver's
//   parallel_out equals the loaded word.
// PARAMETERS
//   WIDTH  8  word length in bits; legal range >= 2
// PORTS
//   clk           in   1      clock; all state updates on posedge
//   rst_n         in   1      reset, synchronous, active-low
//   load_valid    in   1      load_data is valid
//   load_ready    out  1      transmitter can accept a word this cycle
//   load_data     in   WIDTH  word to transmit
//   shift_en      in   1      bit-advance strobe; current bit consumed when high
//   serial_out    out  1      current serial bit (MSB first)
//   serial_valid  out  1      serial_out carries a valid data bit
//   busy          out  1      word in flight (state SHIFT)
//   done          out  1      one-cycle pulse: last bit of a word consumed
// BEHAVIOUR
//   Reset (rst_n low at posedge):
//   - state=IDLE, shift_reg=0, bit_cnt=0, done=0.
//   - serial_out=0, serial_valid=0, busy=0.
//   - load_ready=0 while rst_n low.
//   - Reset mid-word aborts the word with no done pulse.
//   Handshake:
//   - Load fires at a posedge when load_valid && load_ready.
//   - load_data is sampled only at that edge.
//   - load_ready = rst_n && (IDLE || (SHIFT && bit_cnt==WIDTH-1 && shift_en)).
//     It is combinational on shift_en.
//   FSM IDLE:
//   - serial_valid=0, serial_out=0.
//   - On load: shift_reg<=load_data, bit_cnt<=0, go to SHIFT.
//   FSM SHIFT:
//   - serial_valid=1, serial_out=shift_reg[WIDTH-1], busy=1.
//   - shift_en=0: hold all state; serial_out stable.
//   - shift_en=1 and bit_cnt<WIDTH-1: shift_reg<={shift_reg[WIDTH-2:0],1'b0}, bit_cnt++.
//   - shift_en=1 and bit_cnt==WIDTH-1: done<=1 (high exactly one cycle), then
//       * if load_valid: reload (shift_reg<=load_data, bit_cnt<=0), stay in SHIFT.
//         Back-to-back words have zero idle cycles between them.
//       * else: go to IDLE, shift_reg<=0.
//   Timing and widths:
//   - Latency: load accepted at edge T gives the MSB on serial_out in cycle T+1.
//     With shift_en held high, the last bit is consumed at edge T+WIDTH and done
//     is high in cycle T+WIDTH+1.
//   - bit_cnt width = $clog2(WIDTH). bit_cnt never exceeds WIDTH-1 (no wrap).
//   - done is registered and defaults to 0 on all other edges.
//   - load_valid in SHIFT outside the last-bit cycle is ignored (load_ready=0).
//     Data is neither lost nor accepted.
// TESTING
//   1. Reset: rst_n=0 for 2 cycles, load_valid=1.
//      -> load_ready=0, serial_valid=0, serial_out=0, done=0, no load taken.
//   2. Single word: load 8'hA5 with shift_en=1 continuously.
//      -> serial_out sequence 1,0,1,0,0,1,0,1 in cycles T+1..T+8; done=1 in T+9 only;
//      IDLE after.
//   3. Stalls: load 8'h81 and toggle shift_en 1,0,0,1,...
//      -> each bit holds while shift_en=0; exactly 8 consumed bits 1,0,0,0,0,0,0,1;
//      one done pulse.
//   4. Back-to-back: load 8'hF0 then hold load_valid=1 with 8'h0F.
//      -> 16 contiguous valid bits F0 then 0F; load_ready high only in the last-bit
//      cycles; two done pulses 8 cycles apart.
//   5. Loopback: connect to a sipo receiver (WIDTH=8) and send 8'h3C.
//      -> receiver parallel_out==8'h3C in the cycle done is high.
//   6. Reset mid-word: load 8'hFF, pull rst_n low after 3 shifts.
//      -> IDLE next cycle, serial_valid=0, no done pulse; a new load of 8'h01 then
//      transmits correctly.

Source files
------------

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: loads a WIDTH-bit word, shifts it out MSB-first.
// Latency: load at edge T puts the MSB on serial_out in cycle T+1; done pulses the cycle after the last bit.
// Backpressure: shift_en=0 holds the current bit; load_ready is low mid-word, high in IDLE or the last-bit cycle.
module piso_tx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;

    // State register; synchronous reset aborts any word in flight without a done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Next-state and outputs; load_ready is combinational on shift_en so words chain with no gap.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        done_d       = 1'b0;
        load_ready   = 1'b0;
        serial_out   = 1'b0;
        serial_valid = 1'b0;
        busy         = 1'b0;
        case (state_q)
            IDLE: begin
                load_ready = rst_n;
                if (load_valid && rst_n) begin
                    shift_d = load_data;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                serial_valid = 1'b1;
                serial_out   = shift_q[WIDTH-1];
                busy         = 1'b1;
                if (shift_en) begin
                    if (cnt_q == LAST_CNT) begin
                        load_ready = rst_n;
                        done_d     = 1'b1;
                        if (load_valid) begin
                            shift_d = load_data;
                            cnt_d   = '0;
                        end else begin
                            shift_d = '0;
                            cnt_d   = '0;
                            state_d = IDLE;
                        end
                    end else begin
                        shift_d = {shift_q[WIDTH-2:0], 1'b0};
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign done = done_q;

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: bit scoreboard, handshake/done timing, stalls, loopback, reset abort.
// Latency: n/a (testbench).
// Backpressure: drives shift_en patterns including stalls.
module tb_piso_tx;

    logic       clk;
    logic       rst_n;
    logic       load_valid;
    logic       load_ready;
    logic [7:0] load_data;
    logic       shift_en;
    logic       serial_out;
    logic       serial_valid;
    logic       busy;
    logic       done;

    int n_cmp;
    int n_err;
    int done_cnt;
    bit sb[$];
    logic [7:0] rx_sh;

    piso_tx #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_data    (load_data),
        .shift_en     (shift_en),
        .serial_out   (serial_out),
        .serial_valid (serial_valid),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) sb.push_back(w[i]);
    endtask

    // Consumption monitor: a bit is taken at the next posedge when serial_valid && shift_en.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (serial_valid === 1'b1 && shift_en === 1'b1) begin
            rx_sh = {rx_sh[6:0], serial_out};
            if (sb.size() == 0) begin
                chk("unexpected_bit", {31'd0, serial_out}, 32'hFFFF_FFFF);
            end else begin
                chk("bit", {31'd0, serial_out}, {31'd0, sb.pop_front()});
            end
        end
    end

    initial begin
        int d0;
        int guard;
        logic prev_en;
        logic prev_out;
        n_cmp      = 0;
        n_err      = 0;
        done_cnt   = 0;
        rx_sh      = 8'h00;
        rst_n      = 1'b0;
        load_valid = 1'b1;
        load_data  = 8'hAA;
        shift_en   = 1'b0;

        // 1. Reset with load_valid asserted
        tick();
        tick();
        chk("rst_load_ready", {31'd0, load_ready}, 32'd0);
        chk("rst_serial_valid", {31'd0, serial_valid}, 32'd0);
        chk("rst_serial_out", {31'd0, serial_out}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        load_valid = 1'b0;
        rst_n      = 1'b1;
        tick();
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("post_rst_ready", {31'd0, load_ready}, 32'd1);

        // 2. Single word A5, shift_en held high
        shift_en   = 1'b1;
        load_valid = 1'b1;
        load_data  = 8'hA5;
        push_word(8'hA5);
        tick();
        load_valid = 1'b0;
        load_data  = 8'h00;
        chk("a5_valid_t1", {31'd0, serial_valid}, 32'd1);
        chk("a5_msb_t1", {31'd0, serial_out}, 32'd1);
        chk("a5_busy_t1", {31'd0, busy}, 32'd1);
        chk("a5_ready_mid", {31'd0, load_ready}, 32'd0);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("a5_done_early", {31'd0, done}, 32'd0);
        end
        tick();
        chk("a5_done", {31'd0, done}, 32'd1);
        chk("a5_idle_busy", {31'd0, busy}, 32'd0);
        chk("a5_idle_valid", {31'd0, serial_valid}, 32'd0);
        chk("a5_sb_empty", sb.size(), 32'd0);
        tick();
        chk("a5_done_pulse", {31'd0, done}, 32'd0);

        // 3. Word 81 with stalls 1,0,0,...
        d0         = done_cnt;
        load_valid = 1'b1;
        load_data  = 8'h81;
        push_word(8'h81);
        tick();
        load_valid = 1'b0;
        guard      = 0;
        prev_en    = 1'b1;
        prev_out   = serial_out;
        while (sb.size() > 0 && guard < 60) begin
            shift_en = ((guard % 3) == 0);
            if (!prev_en && busy)
                chk("stall_hold", {31'd0, serial_out}, {31'd0, prev_out});
            prev_en  = shift_en;
            prev_out = serial_out;
            tick();
            guard++;
        end
        chk("stall_sb_empty", sb.size(), 32'd0);
        shift_en = 1'b1;
        tick();
        tick();
        chk("stall_one_done", done_cnt - d0, 32'd1);
        chk("stall_idle", {31'd0, busy}, 32'd0);

        // 4. Back-to-back F0 then 0F
        d0         = done_cnt;
        load_valid = 1'b1;
        load_data  = 8'hF0;
        push_word(8'hF0);
        tick();
        load_data = 8'h0F;
        push_word(8'h0F);
        for (int c = 1; c <= 17; c++) begin
            chk($sformatf("b2b_valid_c%0d", c), {31'd0, serial_valid}, {31'd0, (c <= 16)});
            chk($sformatf("b2b_ready_c%0d", c), {31'd0, load_ready},
                {31'd0, (c == 8 || c == 16 || c == 17)});
            chk($sformatf("b2b_done_c%0d", c), {31'd0, done}, {31'd0, (c == 9 || c == 17)});
            tick();
            if (c == 8) load_valid = 1'b0;
        end
        chk("b2b_sb_empty", sb.size(), 32'd0);
        chk("b2b_two_done", done_cnt - d0, 32'd2);

        // 5. Loopback into a receiver model
        load_valid = 1'b1;
        load_data  = 8'h3C;
        push_word(8'h3C);
        tick();
        load_valid = 1'b0;
        guard = 0;
        while (done !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        chk("loop_done_seen", {31'd0, done}, 32'd1);
        chk("loop_rx", {24'd0, rx_sh}, 32'h3C);
        tick();

        // 6. Reset mid-word, then a clean word
        load_valid = 1'b1;
        load_data  = 8'hFF;
        push_word(8'hFF);
        tick();
        load_valid = 1'b0;
        tick();
        tick();
        tick();
        d0    = done_cnt;
        rst_n = 1'b0;
        tick();
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_valid", {31'd0, serial_valid}, 32'd0);
        chk("mid_rst_out", {31'd0, serial_out}, 32'd0);
        chk("mid_rst_ready", {31'd0, load_ready}, 32'd0);
        rst_n = 1'b1;
        sb.delete();
        tick();
        tick();
        chk("mid_rst_no_done", done_cnt - d0, 32'd0);
        load_valid = 1'b1;
        load_data  = 8'h01;
        push_word(8'h01);
        tick();
        load_valid = 1'b0;
        guard = 0;
        while (done !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        chk("after_rst_done", {31'd0, done}, 32'd1);
        chk("after_rst_rx", {24'd0, rx_sh}, 32'h01);
        chk("after_rst_sb_empty", sb.size(), 32'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
